imem_loader: RTL and testbench

Boot-time instruction memory writer. Accepts a stream of 32-bit instruction words over a valid/ready handshake, then writes each word into the byte-wide instruction memory as four big-endian bytes: the byte at the word address gets bits 31:24, and the byte at the word address + 3 gets bits 7:0. This is the byte order the fetch unit uses when it reassembles words. The block holds the core's `fetch_en` low until the load completes and then asserts it, so it sits between the host/test loader and the instruction memory write port, ahead of fetch.

---
 rtl/imem_loader.sv | 174 +++++++++++++++++
 tb/tb_imem_loader.sv | 307 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/imem_loader.sv
// imem_loader
// Boot-time instruction memory writer. Takes 32-bit instruction words over a
// valid/ready handshake. Each word is written to the byte-wide instruction
// memory as four big-endian bytes: the MSB goes to the word address and the
// LSB to word address + 3. fetch_en is held low until the whole load
// completes.
//
// Ports:
//   clk, rst         clock and synchronous active-high reset
//   start            load request pulse (honoured in IDLE/DONE/ERROR)
//   base_addr        byte address of first word (sampled on start)
//   word_count       number of words to load (sampled on start)
//   in_valid/in_data/in_ready   word stream handshake
//   mem_we/mem_addr/mem_wdata   byte write port to instruction memory
//   busy             load in progress (ACCEPT or WRITE)
//   done / fetch_en  sticky load-complete / fetch release
//   err              sticky load-aborted flag
module imem_loader #(
    parameter int INSTR_WIDTH = 32,
    parameter int MEM_DEPTH   = 1024
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   start,
    input  logic [INSTR_WIDTH-1:0] base_addr,
    input  logic [15:0]            word_count,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [INSTR_WIDTH-1:0] in_data,
    output logic                   mem_we,
    output logic [INSTR_WIDTH-1:0] mem_addr,
    output logic [7:0]             mem_wdata,
    output logic                   busy,
    output logic                   done,
    output logic                   err,
    output logic                   fetch_en
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_ACCEPT,
        S_WRITE,
        S_DONE,
        S_ERROR
    } state_t;

    state_t                 r_state;
    logic [INSTR_WIDTH-1:0] r_addr;
    logic [INSTR_WIDTH-1:0] r_word_q;
    logic [15:0]            r_remaining;
    logic [1:0]             r_byte_idx;
    logic                   r_in_ready;
    logic                   r_mem_we;
    logic [INSTR_WIDTH-1:0] r_mem_addr;
    logic [7:0]             r_mem_wdata;
    logic                   r_busy;
    logic                   r_done;
    logic                   r_err;

    logic                   w_misaligned;
    logic                   w_zero_count;
    logic                   w_out_of_range;
    logic [1:0]             w_next_idx;
    logic [7:0]             w_next_byte;

    assign w_misaligned = (base_addr[1:0] != 2'b00);
    assign w_zero_count = (word_count == '0);
    // Compared one bit wider so an address near the top of the space cannot
    // wrap past the bound check.
    assign w_out_of_range = ({1'b0, r_addr} + (INSTR_WIDTH+1)'(3)) >
                            (INSTR_WIDTH+1)'(MEM_DEPTH - 1);
    assign w_next_idx = r_byte_idx + 2'd1;

    // Byte following the one currently on the bus, MSB first.
    always_comb begin
        w_next_byte = '0;
        case (w_next_idx)
            2'd1:    w_next_byte = r_word_q[INSTR_WIDTH-9  -: 8];
            2'd2:    w_next_byte = r_word_q[INSTR_WIDTH-17 -: 8];
            2'd3:    w_next_byte = r_word_q[INSTR_WIDTH-25 -: 8];
            default: w_next_byte = r_word_q[INSTR_WIDTH-1  -: 8];
        endcase
    end

    // Outputs are registered and set on the transition into each state, so
    // the first byte of a word is already on the bus in its first WRITE cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= S_IDLE;
            r_addr      <= '0;
            r_word_q    <= '0;
            r_remaining <= '0;
            r_byte_idx  <= '0;
            r_in_ready  <= 1'b0;
            r_mem_we    <= 1'b0;
            r_mem_addr  <= '0;
            r_mem_wdata <= '0;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
            r_err       <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE, S_DONE, S_ERROR: begin
                    if (start) begin
                        r_done <= 1'b0;
                        r_err  <= 1'b0;
                        if (w_misaligned) begin
                            r_state <= S_ERROR;
                            r_err   <= 1'b1;
                        end else if (w_zero_count) begin
                            r_state <= S_DONE;
                            r_done  <= 1'b1;
                        end else begin
                            r_state     <= S_ACCEPT;
                            r_addr      <= base_addr;
                            r_remaining <= word_count;
                            r_in_ready  <= 1'b1;
                            r_busy      <= 1'b1;
                        end
                    end
                end
                S_ACCEPT: begin
                    if (in_valid) begin
                        r_in_ready <= 1'b0;
                        if (w_out_of_range) begin
                            r_state <= S_ERROR;
                            r_busy  <= 1'b0;
                            r_err   <= 1'b1;
                        end else begin
                            r_state     <= S_WRITE;
                            r_word_q    <= in_data;
                            r_byte_idx  <= '0;
                            r_mem_we    <= 1'b1;
                            r_mem_addr  <= r_addr;
                            r_mem_wdata <= in_data[INSTR_WIDTH-1 -: 8];
                        end
                    end
                end
                S_WRITE: begin
                    if (r_byte_idx != 2'd3) begin
                        r_byte_idx  <= w_next_idx;
                        r_mem_addr  <= r_addr + INSTR_WIDTH'(w_next_idx);
                        r_mem_wdata <= w_next_byte;
                    end else begin
                        r_mem_we    <= 1'b0;
                        r_addr      <= r_addr + INSTR_WIDTH'(4);
                        r_remaining <= r_remaining - 16'd1;
                        if (r_remaining == 16'd1) begin
                            r_state <= S_DONE;
                            r_busy  <= 1'b0;
                            r_done  <= 1'b1;
                        end else begin
                            r_state    <= S_ACCEPT;
                            r_in_ready <= 1'b1;
                        end
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign in_ready  = r_in_ready;
    assign mem_we    = r_mem_we;
    assign mem_addr  = r_mem_addr;
    assign mem_wdata = r_mem_wdata;
    assign busy      = r_busy;
    assign done      = r_done;
    assign err       = r_err;
    assign fetch_en  = r_done;

endmodule

// File: tb/tb_imem_loader.sv
// Self-checking bench for imem_loader: expected byte writes go into a
// scoreboard queue when a word is handed over and are popped by a monitor
// whenever mem_we is seen.
module tb_imem_loader;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [31:0] base_addr;
    logic [15:0] word_count;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_data;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [7:0]  mem_wdata;
    logic        busy;
    logic        done;
    logic        err;
    logic        fetch_en;

    always #5 clk = ~clk;

    imem_loader #(.INSTR_WIDTH(32), .MEM_DEPTH(1024)) dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .base_addr  (base_addr),
        .word_count (word_count),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_data    (in_data),
        .mem_we     (mem_we),
        .mem_addr   (mem_addr),
        .mem_wdata  (mem_wdata),
        .busy       (busy),
        .done       (done),
        .err        (err),
        .fetch_en   (fetch_en)
    );

    int errors = 0;
    int checks = 0;

    typedef struct {
        logic [31:0] addr;
        logic [7:0]  data;
    } wr_t;
    wr_t sb_q[$];
    wr_t mon_e;

    typedef struct {
        logic [31:0] base;
        logic [15:0] cnt;
        logic [31:0] seed;
        logic        exp_done;
        logic        exp_err;
    } vec_t;
    vec_t vecs[9];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic push_word(input logic [31:0] a, input logic [31:0] w);
        for (int unsigned b = 0; b < 4; b++) begin
            wr_t e;
            e.addr = a + b;
            e.data = 8'(w >> (24 - 8 * b));
            sb_q.push_back(e);
        end
    endtask

    // Monitor: every write strobe must match the next expected byte.
    always @(negedge clk) begin
        if (mem_we === 1'b1) begin
            if (sb_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL spurious_write: got addr %0h data %0h expected no write",
                         mem_addr, mem_wdata);
            end else begin
                mon_e = sb_q.pop_front();
                chk("wr_addr", mem_addr, mon_e.addr);
                chk("wr_data", {24'h0, mem_wdata}, {24'h0, mon_e.data});
            end
        end
    end

    task automatic wait_flag(output int n);
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!(done || err) && n < 40);
    endtask

    task automatic pulse_start(input logic [31:0] b, input logic [15:0] c);
        @(posedge clk); #1;
        base_addr  = b;
        word_count = c;
        start      = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    // Full load; the model decides which words land in memory.
    task automatic run_load(input vec_t v);
        logic [31:0] a;
        int          n;
        int          lat;
        bit          dropped;
        lat = 1;
        dropped = 0;
        pulse_start(v.base, v.cnt);
        if (v.base[1:0] == 2'b00 && v.cnt != 0) begin
            a = v.base;
            for (int unsigned i = 0; i < v.cnt && !dropped; i++) begin
                in_valid = 1'b1;
                in_data  = v.seed + i * 32'h01010101;
                n = 0;
                do begin
                    @(negedge clk);
                    n++;
                end while (!in_ready && n < 40);
                chk("ready_wait", {31'b0, in_ready}, 1);
                if (!in_ready) begin
                    in_valid = 1'b0;
                    return;
                end
                if (a + 3 > 1023) dropped = 1;
                else push_word(a, in_data);
                a = a + 4;
                @(posedge clk); #1;
                in_valid = 1'b0;
            end
            lat = dropped ? 1 : 5;
        end
        wait_flag(n);
        chk("flag_latency", n, lat);
        chk("done", {31'b0, done}, {31'b0, v.exp_done});
        chk("err", {31'b0, err}, {31'b0, v.exp_err});
        chk("fetch_en", {31'b0, fetch_en}, {31'b0, v.exp_done});
        chk("busy_idle", {31'b0, busy}, 0);
        chk("ready_idle", {31'b0, in_ready}, 0);
        chk("sb_drain", sb_q.size(), 0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int          xfers;
        int          ready_cycles;
        int          last_we;
        int          rise;
        int          n;
        bit          got;
        logic [31:0] a;
        vec_t        v;

        vecs[0] = '{32'h000, 16'd2, 32'h11223344, 1'b1, 1'b0};
        vecs[1] = '{32'h100, 16'd3, 32'h89ABCDEF, 1'b1, 1'b0};
        vecs[2] = '{32'h002, 16'd1, 32'h0,        1'b0, 1'b1};
        vecs[3] = '{32'h040, 16'd0, 32'h0,        1'b1, 1'b0};
        vecs[4] = '{32'd1020, 16'd2, 32'hF0E1D2C3, 1'b0, 1'b1};
        vecs[5] = '{32'd1024, 16'd1, 32'h55667788, 1'b0, 1'b1};
        vecs[6] = '{32'd1016, 16'd2, 32'h0F1E2D3C, 1'b1, 1'b0};
        vecs[7] = '{32'h001, 16'd5, 32'h0,        1'b0, 1'b1};
        vecs[8] = '{32'h003, 16'd0, 32'h0,        1'b0, 1'b1};

        rst = 1'b1; start = 1'b0; base_addr = '0; word_count = '0;
        in_valid = 1'b0; in_data = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_in_ready", {31'b0, in_ready}, 0);
        chk("rst_mem_we", {31'b0, mem_we}, 0);
        chk("rst_busy", {31'b0, busy}, 0);
        chk("rst_done", {31'b0, done}, 0);
        chk("rst_err", {31'b0, err}, 0);
        chk("rst_fetch_en", {31'b0, fetch_en}, 0);
        chk("rst_mem_addr", mem_addr, 0);
        chk("rst_mem_wdata", {24'h0, mem_wdata}, 0);
        @(posedge clk); #1;
        rst = 1'b0;

        // Basic load with in_valid held high; cycle k is the k-th cycle after start.
        @(posedge clk); #1;
        base_addr = 0; word_count = 2; in_valid = 1'b1; in_data = 32'h12345678; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        xfers = 0; ready_cycles = 0; last_we = 0; rise = 0; a = 0;
        for (int k = 1; k <= 14; k++) begin
            @(negedge clk);
            got = 0;
            if (in_ready) ready_cycles++;
            if (in_ready && in_valid) begin
                push_word(a, in_data);
                a = a + 4;
                xfers++;
                got = 1;
            end
            if (mem_we) last_we = k;
            if (fetch_en && rise == 0) rise = k;
            @(posedge clk); #1;
            if (got) begin
                if (xfers == 1) in_data = 32'hA1B2C3D4;
                else in_valid = 1'b0;
            end
        end
        chk("basic_xfers", xfers, 2);
        chk("basic_ready_cycles", ready_cycles, 2);
        chk("basic_fetch_rise", rise, 11);
        chk("basic_last_we", last_we, 10);
        chk("basic_done", {31'b0, done}, 1);
        chk("basic_drain", sb_q.size(), 0);

        // Backpressure: three idle cycles in ACCEPT.
        pulse_start(32'h200, 16'd1);
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            chk("bp_ready", {31'b0, in_ready}, 1);
            chk("bp_no_we", {31'b0, mem_we}, 0);
            @(posedge clk); #1;
        end
        in_valid = 1'b1; in_data = 32'hCAFEF00D;
        @(negedge clk);
        chk("bp_ready_on_valid", {31'b0, in_ready}, 1);
        push_word(32'h200, in_data);
        @(posedge clk); #1;
        in_valid = 1'b0;
        @(negedge clk);
        chk("bp_we_next", {31'b0, mem_we}, 1);
        wait_flag(n);
        chk("bp_done", {31'b0, done}, 1);
        chk("bp_drain", sb_q.size(), 0);

        // Reset while byte 1 of a word is on the bus.
        pulse_start(32'h0, 16'd2);
        in_valid = 1'b1; in_data = 32'h55AA33CC;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!in_ready && n < 40);
        chk("rw_ready", {31'b0, in_ready}, 1);
        push_word(32'h0, in_data);
        @(posedge clk); #1;
        in_valid = 1'b0;
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        chk("rw_pending_bytes", sb_q.size(), 2);
        sb_q.delete();
        @(negedge clk);
        chk("rw_in_ready", {31'b0, in_ready}, 0);
        chk("rw_mem_we", {31'b0, mem_we}, 0);
        chk("rw_busy", {31'b0, busy}, 0);
        chk("rw_done", {31'b0, done}, 0);
        chk("rw_err", {31'b0, err}, 0);
        chk("rw_fetch_en", {31'b0, fetch_en}, 0);
        chk("rw_mem_addr", mem_addr, 0);
        chk("rw_mem_wdata", {24'h0, mem_wdata}, 0);
        repeat (3) @(posedge clk);
        v = '{32'h0, 16'd1, 32'hDEADBEEF, 1'b1, 1'b0};
        run_load(v);

        // Restart from DONE, with start pulses during ACCEPT and WRITE.
        pulse_start(32'd16, 16'd1);
        base_addr = 32'h2;
        @(negedge clk);
        chk("rs_fetch_drop", {31'b0, fetch_en}, 0);
        chk("rs_done_drop", {31'b0, done}, 0);
        chk("rs_ready", {31'b0, in_ready}, 1);
        @(posedge clk); #1;
        start = 1'b1; in_valid = 1'b1; in_data = 32'h0BADF00D;
        @(negedge clk);
        chk("rs_ready2", {31'b0, in_ready}, 1);
        push_word(32'd16, in_data);
        @(posedge clk); #1;
        start = 1'b0; in_valid = 1'b0;
        @(posedge clk); #1;
        base_addr = 32'h80; word_count = 16'd0; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        wait_flag(n);
        chk("rs_err", {31'b0, err}, 0);
        chk("rs_done", {31'b0, done}, 1);
        chk("rs_fetch_en", {31'b0, fetch_en}, 1);
        chk("rs_drain", sb_q.size(), 0);

        for (int i = 0; i < 9; i++) run_load(vecs[i]);

        repeat (3) @(posedge clk);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
